// File: rtl/text_buf_loader.sv
// Copies one ROM message into a 32-column row of the character buffer.
// Buffer writes happen only during vertical blanking.
module text_buf_loader #(
    parameter int unsigned MSG_COUNT  = 4,
    parameter logic [7:0]  BLANK_CHAR = 8'h20,
    parameter logic [7:0]  TERM_CHAR  = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       msg_req,
    input  logic [1:0] msg_id,
    input  logic [2:0] msg_row,
    output logic       busy,
    output logic       msg_ack,
    output logic [6:0] msg_rom_addr,
    input  logic [7:0] msg_rom_data,
    output logic       buf_we,
    output logic [7:0] buf_addr,
    output logic [7:0] buf_wdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VBL,
        FETCH,
        WRITE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] col_q, col_d;
    logic       pad_q, pad_d;
    logic [1:0] id_q, id_d;
    logic [2:0] row_q, row_d;
    logic       busy_q, busy_d;
    logic       ack_q, ack_d;
    logic       we_q, we_d;
    logic [6:0] rom_addr_q, rom_addr_d;
    logic [7:0] baddr_q, baddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       is_term;

    assign is_term = (msg_rom_data == TERM_CHAR);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        pad_d      = pad_q;
        id_d       = id_q;
        row_d      = row_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        we_d       = 1'b0;
        rom_addr_d = rom_addr_q;
        baddr_d    = baddr_q;
        wdata_d    = wdata_q;
        unique case (state_q)
            IDLE: begin
                // busy stays high through the ack cycle, then follows msg_req
                busy_d = msg_req;
                if (msg_req) begin
                    id_d    = msg_id;
                    row_d   = msg_row;
                    col_d   = 5'd0;
                    pad_d   = ({30'd0, msg_id} >= MSG_COUNT);
                    state_d = WAIT_VBL;
                end
            end
            WAIT_VBL: begin
                if (vblnk) begin
                    rom_addr_d = {id_q, col_q};
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                state_d = vblnk ? WRITE : WAIT_VBL;
            end
            WRITE: begin
                if (!vblnk) begin
                    state_d = WAIT_VBL;
                end else begin
                    we_d    = 1'b1;
                    baddr_d = {col_q, row_q};
                    wdata_d = (pad_q || is_term) ? BLANK_CHAR : msg_rom_data;
                    if (is_term) begin
                        pad_d = 1'b1;
                    end
                    if (col_q == 5'd31) begin
                        ack_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        col_d      = col_q + 5'd1;
                        rom_addr_d = {id_q, col_q + 5'd1};
                        state_d    = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            col_q      <= 5'd0;
            pad_q      <= 1'b0;
            id_q       <= 2'd0;
            row_q      <= 3'd0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            we_q       <= 1'b0;
            rom_addr_q <= 7'd0;
            baddr_q    <= 8'd0;
            wdata_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            pad_q      <= pad_d;
            id_q       <= id_d;
            row_q      <= row_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            we_q       <= we_d;
            rom_addr_q <= rom_addr_d;
            baddr_q    <= baddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign busy         = busy_q;
    assign msg_ack      = ack_q;
    assign buf_we       = we_q;
    assign msg_rom_addr = rom_addr_q;
    assign buf_addr     = baddr_q;
    assign buf_wdata    = wdata_q;

endmodule

// File: tb/tb_text_buf_loader.sv
// Bench for text_buf_loader: synchronous ROM model, per-write reference
// model of the expected row contents, and directed scenarios.
module tb_text_buf_loader;

    localparam int NMSG = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       vblnk;
    logic       msg_req;
    logic [1:0] msg_id;
    logic [2:0] msg_row;
    logic       busy;
    logic       msg_ack;
    logic [6:0] msg_rom_addr;
    logic [7:0] msg_rom_data;
    logic       buf_we;
    logic [7:0] buf_addr;
    logic [7:0] buf_wdata;

    logic [7:0] rom [0:127];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    int ld_id  [0:15];
    int ld_row [0:15];
    int n_loads = 0;
    int cur     = 0;
    int wr_col  = 0;
    logic vbl_e = 1'b0;

    text_buf_loader #(
        .MSG_COUNT(NMSG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vblnk       (vblnk),
        .msg_req     (msg_req),
        .msg_id      (msg_id),
        .msg_row     (msg_row),
        .busy        (busy),
        .msg_ack     (msg_ack),
        .msg_rom_addr(msg_rom_addr),
        .msg_rom_data(msg_rom_data),
        .buf_we      (buf_we),
        .buf_addr    (buf_addr),
        .buf_wdata   (buf_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) msg_rom_data <= rom[msg_rom_addr];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Row content from the message rules: text up to the terminator, then blanks.
    function automatic logic [7:0] exp_char(input int id, input int col);
        if (id >= NMSG) return 8'h20;
        for (int k = 0; k <= col; k++)
            if (rom[id*32 + k] == 8'h00) return 8'h20;
        return rom[id*32 + col];
    endfunction

    task automatic add_load(input int id, input int row);
        ld_id[n_loads]  = id;
        ld_row[n_loads] = row;
        n_loads++;
    endtask

    task automatic req_pulse(input int id, input int row);
        @(negedge clk);
        msg_req = 1'b1;
        msg_id  = id[1:0];
        msg_row = row[2:0];
        @(negedge clk);
        msg_req = 1'b0;
    endtask

    task automatic wait_ack(input string name, input int budget);
        int c = 0;
        while (!msg_ack && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, msg_ack, 1);
    endtask

    task automatic wait_col(input string name, input int col, input int budget);
        int c = 0;
        while (!(buf_we && buf_addr[7:3] == col[4:0]) && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, buf_we, 1);
    endtask

    task automatic quiet(input int n, output int we_cnt);
        we_cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (buf_we) we_cnt++;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                wr_col = 0;
                cur    = n_loads;
            end else if (buf_we) begin
                if (cur >= n_loads) begin
                    chk("unexpected_write", buf_we, 0);
                end else begin
                    chk("wr_addr", buf_addr, {wr_col[4:0], ld_row[cur][2:0]});
                    chk("wr_data", buf_wdata, exp_char(ld_id[cur], wr_col));
                    chk("wr_in_vblnk", vbl_e, 1);
                    chk("wr_ack", msg_ack, (wr_col == 31));
                    wr_col++;
                    if (wr_col == 32) begin
                        wr_col = 0;
                        cur++;
                    end
                end
            end else begin
                chk("ack_without_we", msg_ack, 0);
            end
        end
    endtask

    initial begin
        string s2;
        int c;
        int wc;
        for (int i = 0; i < 128; i++) rom[i] = 8'h00;
        rom[0] = "H"; rom[1] = "E"; rom[2] = "L"; rom[3] = "L"; rom[4] = "O";
        rom[32] = "G"; rom[33] = "O";
        s2 = "ABCDEFGHIJKLMNOPQRSTUVWXYZ012345";
        for (int i = 0; i < 32; i++) rom[64 + i] = s2[i];
        rom[96] = "Z"; rom[97] = "Z";

        chk("model_G", exp_char(1, 0), 8'h47);
        chk("model_pad", exp_char(1, 2), 8'h20);
        chk("model_full", exp_char(2, 31), 8'h35);

        rst = 1'b0; vblnk = 1'b0; msg_req = 1'b0; msg_id = 2'd0; msg_row = 3'd0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ack", msg_ack, 0);
        chk("rst_we", buf_we, 0);
        chk("rst_romaddr", msg_rom_addr, 0);
        chk("rst_addr", buf_addr, 0);
        chk("rst_wdata", buf_wdata, 0);

        fork
            monitor();
            forever begin
                @(posedge clk);
                vbl_e = vblnk;
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b1;

        // message 1 "GO" into row 3
        @(negedge clk);
        vblnk = 1'b1; msg_id = 2'd1; msg_row = 3'd3; msg_req = 1'b1;
        add_load(1, 3);
        @(negedge clk);
        msg_req = 1'b0;
        chk("t1_busy", busy, 1);
        c = 0;
        while (!buf_we && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("t1_first_lat", c, 3);
        chk("t1_first_addr", buf_addr, 8'h03);
        chk("t1_first_data", buf_wdata, 8'h47);
        @(negedge clk);
        chk("t1_gap", buf_we, 0);
        @(negedge clk);
        chk("t1_second_addr", buf_addr, 8'h0B);
        chk("t1_second_data", buf_wdata, 8'h4F);
        c = 0;
        while (!msg_ack && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("t1_ack_lat", c, 60);
        chk("t1_ack_addr", buf_addr, 8'hFB);
        chk("t1_ack_data", buf_wdata, 8'h20);
        chk("t1_ack_busy", busy, 1);
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);

        // request during active video, plus an ignored request mid-load
        vblnk = 1'b0;
        req_pulse(2, 5);
        add_load(2, 5);
        quiet(10, wc);
        chk("t2_no_we", wc, 0);
        chk("t2_busy", busy, 1);
        vblnk = 1'b1;
        c = 0;
        while (!buf_we && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("t2_start_lat", c, 3);
        req_pulse(0, 7);
        wait_ack("t2_ack", 100);
        quiet(3, wc);
        chk("t2_no_reload", wc, 0);
        chk("t2_idle_busy", busy, 0);

        // vblnk drops after col 10 (FETCH) and during col 21 (WRITE)
        req_pulse(0, 1);
        add_load(0, 1);
        wait_col("t3_col10", 10, 50);
        vblnk = 1'b0;
        quiet(20, wc);
        chk("t3_pause_we", wc, 0);
        vblnk = 1'b1;
        @(negedge clk);
        chk("t3_refetch", msg_rom_addr, 7'h0B);
        wait_col("t3_col20", 20, 50);
        @(negedge clk);
        vblnk = 1'b0;
        quiet(5, wc);
        chk("t3_pause2_we", wc, 0);
        vblnk = 1'b1;
        wait_ack("t3_ack", 100);

        // invalid id pads the whole row
        req_pulse(3, 6);
        add_load(3, 6);
        wait_col("t4_col0", 0, 20);
        chk("t4_first_data", buf_wdata, 8'h20);
        wait_ack("t4_ack", 100);
        chk("t4_ack_addr", buf_addr, 8'hFE);

        // msg_req held: back-to-back reload with new id/row
        @(negedge clk);
        msg_req = 1'b1; msg_id = 2'd2; msg_row = 3'd0;
        add_load(2, 0);
        @(negedge clk);
        chk("t5_busy", busy, 1);
        msg_id = 2'd0; msg_row = 3'd2;
        add_load(0, 2);
        wait_ack("t5_ack1", 100);
        @(negedge clk);
        msg_req = 1'b0;
        chk("t5_reaccept", busy, 1);
        wait_ack("t5_ack2", 100);
        @(negedge clk);
        chk("t5_idle", busy, 0);

        chk("loads_done", cur, n_loads);
        chk("no_partial", wr_col, 0);

        // asynchronous reset mid-load
        req_pulse(1, 4);
        add_load(1, 4);
        wait_col("t6_col5", 5, 30);
        #2 rst = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_ack", msg_ack, 0);
        chk("t6_we", buf_we, 0);
        chk("t6_romaddr", msg_rom_addr, 0);
        chk("t6_addr", buf_addr, 0);
        chk("t6_wdata", buf_wdata, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        quiet(10, wc);
        chk("t6_no_resume", wc, 0);
        chk("t6_idle", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
